// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (RV32M DIV/DIVU/REM/REMU).
// One quotient bit per cycle, MSB first. Divide-by-zero and signed overflow
// are resolved at start acceptance and bypass the iteration entirely.
// The held result feeds the writeback result-select mux; busy stalls the pipe.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Magnitude of a value when it is treated as signed.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
        abs_val = (is_signed && v[WIDTH-1]) ? (ZERO - v) : v;
    endfunction

    // Conditional two's-complement negation used by the sign fix-up.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                input logic             neg);
        neg_if = neg ? (ZERO - v) : v;
    endfunction

    state_t             state_r;
    state_t             state_next;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_r;
    logic               sel_rem_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [WIDTH-1:0]   quot_r;
    logic [WIDTH:0]     rem_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               accept_s;
    logic               signed_op_s;
    logic               div_zero_s;
    logic               overflow_s;
    logic               special_s;
    logic [WIDTH-1:0]   special_res_s;
    logic               last_s;
    logic [WIDTH+1:0]   shifted_s;
    logic [WIDTH+1:0]   trial_s;
    logic [WIDTH:0]     rem_next_s;
    logic [WIDTH-1:0]   quot_next_s;
    logic [WIDTH-1:0]   quot_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Classify the incoming operands and precompute the bypass result.
    always_comb begin
        signed_op_s   = ~op[0];
        div_zero_s    = (b == ZERO);
        overflow_s    = signed_op_s && (a == MOST_NEG) && (b == ALL_ONES);
        special_s     = div_zero_s || overflow_s;
        special_res_s = ZERO;
        if (div_zero_s) begin
            special_res_s = op[1] ? a : ALL_ONES;
        end else begin
            special_res_s = op[1] ? ZERO : a;
        end
    end

    // One restoring step plus the sign fix-up applied on the last step.
    always_comb begin
        last_s      = (cnt_r == LAST_CNT);
        shifted_s   = {rem_r, quot_r[WIDTH-1]};
        trial_s     = shifted_s - {2'b00, divisor_r};
        rem_next_s  = shifted_s[WIDTH:0];
        quot_next_s = {quot_r[WIDTH-2:0], 1'b0};
        if (!trial_s[WIDTH+1]) begin
            rem_next_s  = trial_s[WIDTH:0];
            quot_next_s = {quot_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s  = shifted_s[WIDTH:0];
            quot_next_s = {quot_r[WIDTH-2:0], 1'b0};
        end
        quot_fix_s = neg_if(quot_next_s, neg_q_r);
        rem_fix_s  = neg_if(rem_next_s[WIDTH-1:0], neg_r_r);
    end

    // Next-state logic; flush beats start in IDLE and aborts CALC.
    always_comb begin
        state_next = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (start) begin
                    accept_s   = 1'b1;
                    state_next = special_s ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last_s) begin
                    state_next = DONE;
                end else begin
                    state_next = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_next = special_s ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            busy_r  <= (state_next == CALC);
            done_r  <= (state_next == DONE);
        end
    end

    // Operand capture, iteration registers and the held result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_rem_r <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            divisor_r <= ZERO;
            quot_r    <= ZERO;
            rem_r     <= {(WIDTH+1){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            result_r  <= ZERO;
        end else if (accept_s) begin
            sel_rem_r <= op[1];
            neg_q_r   <= signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r   <= signed_op_s && a[WIDTH-1];
            divisor_r <= abs_val(b, signed_op_s);
            quot_r    <= abs_val(a, signed_op_s);
            rem_r     <= {(WIDTH+1){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            if (special_s) begin
                result_r <= special_res_s;
            end
        end else if ((state_r == CALC) && !flush) begin
            quot_r <= quot_next_s;
            rem_r  <= rem_next_s;
            cnt_r  <= cnt_r + CNT_W'(1);
            if (last_s) begin
                result_r <= sel_rem_r ? rem_fix_s : quot_fix_s;
            end
        end
    end

endmodule
